median_window_gen: RTL

Upstream feeder for the 3x3 median filter stage. Accepts a raster-order 8-bit pixel stream one pixel per accepted beat and buffers the two previous image lines. Emits each fully interior 3x3 neighbourhood as nine registered pixel outputs with a valid/ready handshake. The nine outputs wire directly to the median stage's `add_1`..`add_9` inputs, and `win_valid` drives its data-qualify input.

---
 rtl/median_window_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/median_window_gen.sv
// 3x3 window generator feeding the median filter, two line buffers deep.
// Optional MEDWIN_CNT_EN adds a 16-bit consumed-window counter output.
module median_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        tx_ready,
    output logic [7:0]  win_1,
    output logic [7:0]  win_2,
    output logic [7:0]  win_3,
    output logic [7:0]  win_4,
    output logic [7:0]  win_5,
    output logic [7:0]  win_6,
    output logic [7:0]  win_7,
    output logic [7:0]  win_8,
    output logic [7:0]  win_9,
    output logic        win_valid,
`ifdef MEDWIN_CNT_EN
    output logic [15:0] win_count,
`endif
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {
        S_PRIME,
        S_STREAM
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          frame_end;
    logic          emit;
    logic [7:0]    top_px;
    logic [7:0]    mid_px;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    w   [9];

    assign pix_ready = rst_n && (!win_valid || tx_ready);
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col == CW'(IMG_W - 1));
    assign row_last  = (row == RW'(IMG_H - 1));
    assign frame_end = accept && row_last && col_last;
    assign top_px    = lb0[col];
    assign mid_px    = lb1[col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PRIME;
        end else begin
            state <= state_nx;
        end
    end

    // Windows only leave while streaming rows 2.. and once three columns exist
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        unique case (state)
            S_PRIME: begin
                if (accept && row == RW'(1) && col_last) begin
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                emit = accept && (col >= CW'(2));
                if (frame_end) begin
                    state_nx = S_PRIME;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers are not reset; the priming rows overwrite them
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= mid_px;
            lb1[col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                w[i] <= '0;
            end
        end else if (accept) begin
            w[0] <= w[1];
            w[1] <= w[2];
            w[2] <= top_px;
            w[3] <= w[4];
            w[4] <= w[5];
            w[5] <= mid_px;
            w[6] <= w[7];
            w[7] <= w[8];
            w[8] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (accept) begin
                win_valid <= emit;
            end else if (tx_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef MEDWIN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (win_valid && tx_ready) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

    assign win_1 = w[0];
    assign win_2 = w[1];
    assign win_3 = w[2];
    assign win_4 = w[3];
    assign win_5 = w[4];
    assign win_6 = w[5];
    assign win_7 = w[6];
    assign win_8 = w[7];
    assign win_9 = w[8];

endmodule
